// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM arbiter/sequencer shared by instruction fetch and MEM stage
// Optional fetch-abort port flush_i is present when MEM_CTRL_IF_FLUSH_EN is defined.
module mem_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [31:0]       if_inst_o,
   output logic              if_done_o,
   output logic              if_stall_req_o,
   input  logic              mem_req_i,
   input  logic              mem_we_i,
   input  logic [1:0]        mem_width_i,
   input  logic              mem_sign_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [31:0]       mem_wdata_i,
   output logic [31:0]       mem_rdata_o,
   output logic              mem_done_o,
   output logic              mem_stall_req_o,
`ifdef MEM_CTRL_IF_FLUSH_EN
   input  logic              flush_i,
`endif
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_wr_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]        state;
   logic [2:0]        k;
   logic [2:0]        n;
   logic              owner_mem;
   logic [ADDR_W-1:0] base;
   logic [1:0]        width;
   logic              sign;
   logic [3:0][7:0]   wdata;
   logic [3:0][7:0]   lanes;

   logic [3:0][7:0]   rd_bytes;
   logic [31:0]       load_val;
   logic [1:0]        lane_idx;
   logic [2:0]        mem_n;
   logic              flush_hit;

`ifdef MEM_CTRL_IF_FLUSH_EN
   assign flush_hit = flush_i && (state == S_RD) && !owner_mem;
`else
   assign flush_hit = 1'b0;
`endif

   always_comb begin
      mem_n = 3'd4;
      if (mem_width_i == 2'b00) mem_n = 3'd1;
      else if (mem_width_i == 2'b01) mem_n = 3'd2;
   end

   // The byte arriving this cycle belongs to the address driven last cycle (lane k-1).
   always_comb begin
      lane_idx = 2'(k - 3'd1);
      rd_bytes = lanes;
      if (state == S_RD && k != 3'd0) rd_bytes[lane_idx] = ram_din_i;
   end

   always_comb begin
      case (width)
         2'b00:   load_val = {{24{rd_bytes[0][7] & sign}}, rd_bytes[0]};
         2'b01:   load_val = {{16{rd_bytes[1][7] & sign}}, rd_bytes[1], rd_bytes[0]};
         default: load_val = rd_bytes;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         k           <= 3'd0;
         n           <= 3'd0;
         owner_mem   <= 1'b0;
         base        <= '0;
         width       <= 2'b00;
         sign        <= 1'b0;
         wdata       <= '0;
         lanes       <= '0;
         if_inst_o   <= 32'd0;
         mem_rdata_o <= 32'd0;
      end else if (rdy) begin
         case (state)
            S_IDLE: begin
               owner_mem <= 1'b0;
               k         <= 3'd0;
               if (mem_req_i) begin
                  owner_mem <= 1'b1;
                  base      <= mem_addr_i;
                  width     <= mem_width_i;
                  sign      <= mem_sign_i;
                  wdata     <= mem_wdata_i;
                  n         <= mem_n;
                  state     <= mem_we_i ? S_WR : S_RD;
               end else if (if_req_i) begin
                  base  <= if_addr_i;
                  width <= 2'b10;
                  sign  <= 1'b0;
                  n     <= 3'd4;
                  state <= S_RD;
               end
            end
            S_RD: begin
               if (flush_hit) begin
                  state <= S_IDLE;
                  k     <= 3'd0;
               end else begin
                  lanes <= rd_bytes;
                  // Results are registered on entry to DONE so they are valid with the pulse.
                  if (k == n) begin
                     state <= S_DONE;
                     if (owner_mem) mem_rdata_o <= load_val;
                     else           if_inst_o   <= rd_bytes;
                  end else begin
                     k <= k + 3'd1;
                  end
               end
            end
            S_WR: begin
               if (k == n - 3'd1) state <= S_DONE;
               else               k     <= k + 3'd1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      ram_addr_o = '0;
      ram_dout_o = 8'h00;
      if ((state == S_RD && k < n) || state == S_WR) ram_addr_o = base + ADDR_W'(k);
      if (state == S_WR) ram_dout_o = wdata[k[1:0]];
   end

   assign ram_wr_o        = (state == S_WR) && rdy;
   assign if_done_o       = (state == S_DONE) && !owner_mem;
   assign mem_done_o      = (state == S_DONE) && owner_mem;
   assign if_stall_req_o  = if_req_i & ~if_done_o;
   assign mem_stall_req_o = mem_req_i & ~mem_done_o;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Arbiter and sequencer for the single byte-wide RAM port shared by instruction fetch and the MEM stage. Each requester gets a level request/done handshake. The controller serialises each request into 1, 2 or 4 byte accesses, then assembles read bytes little-endian and sign- or zero-extends loads. It sits between the pipeline stages and the RAM, and its stall requests feed `ctrl`.

## Interface
Parameters:
- `ADDR_W`, 32: address width of requester and RAM addresses.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global pause; low means hold all state. The RAM pauses with it and holds `ram_din_i`.
- `if_req_i`  in  1  fetch request, level.
- `if_addr_i`  in  ADDR_W  fetch PC.
- `if_inst_o`  out  32  fetched word, registered, held until the next IF grant.
- `if_done_o`  out  1  one-cycle completion pulse for IF.
- `if_stall_req_o`  out  1  `if_req_i & ~if_done_o`.
- `mem_req_i`  in  1  load/store request, level.
- `mem_we_i`  in  1  1 = store, 0 = load.
- `mem_width_i`  in  2  00 byte, 01 half, 10/11 word.
- `mem_sign_i`  in  1  1 = sign-extend a load, 0 = zero-extend.
- `mem_addr_i`  in  ADDR_W  byte address.
- `mem_wdata_i`  in  32  store data; the low N bytes are used.
- `mem_rdata_o`  out  32  load result, registered, held until the next MEM load.
- `mem_done_o`  out  1  one-cycle completion pulse for MEM.
- `mem_stall_req_o`  out  1  `mem_req_i & ~mem_done_o`.
- `flush_i`  in  1  abort an in-flight fetch. Present only with `MEM_CTRL_IF_FLUSH_EN`.
- `ram_din_i`  in  8  RAM read data; it returns the byte addressed in the previous active cycle.
- `ram_dout_o`  out  8  RAM write data.
- `ram_addr_o`  out  ADDR_W  RAM address.
- `ram_wr_o`  out  1  RAM write enable.

## Operation
States and transitions:
- States: IDLE, RD, WR, DONE.
- IDLE: MEM has priority over IF.
  - `mem_req_i` high: latch addr/width/sign/wdata, N = 1/2/4. Go to WR if `mem_we_i`, else RD.
  - Otherwise, if `if_req_i` is high: latch `if_addr_i`, N = 4, go to RD.
- Owner bit records the granted requester; it is cleared in IDLE.

Byte counter `k`:
- Counts from 0 to N, is 3 bits wide, and resets on every grant.
- The address for byte `k` is base+k, computed modulo 2^ADDR_W. There is no alignment check.

RD state (N+1 active cycles):
- In cycle `k < N`, drive `ram_addr_o` = base+k.
- In cycle `k ≥ 1`, capture `ram_din_i` into byte lane k−1.
- After the capture at k = N, go to DONE.

WR state (N active cycles):
- In cycle `k`: `ram_wr_o` = 1, `ram_addr_o` = base+k, `ram_dout_o` = wdata[8k+7:8k].
- After k = N−1, go to DONE.

DONE (1 cycle):
- Pulse the owner's done output.
- Update `mem_rdata_o` only for a load: byte → {24{b0[7]&sign}, b0}, half → {16{b1[7]&sign}, b1, b0}, word → {b3, b2, b1, b0}.
- For IF, `if_inst_o` = {b3, b2, b1, b0}.
- Next state is IDLE.
- Requesters must drop their request in the cycle after done, otherwise they are re-granted.

`ram_wr_o` is 0 in every state except WR.

## Timing
- Reset, and when `rdy` is high with `rst` high: state IDLE, k = 0, owner = 0.
- Reset values of outputs: `if_inst_o` = 0, `mem_rdata_o` = 0, `if_done_o` = `mem_done_o` = 0, `ram_addr_o` = 0, `ram_dout_o` = 0, `ram_wr_o` = 0.
- Read: request seen in IDLE at cycle 0; RD occupies cycles 1..N+1; done in cycle N+2.
  - Word fetch/load: done in cycle 6.
  - Byte load: done in cycle 3.
- Write: WR occupies cycles 1..N; done in cycle N+1 (word store: done in cycle 5).
- Minimum gap between transactions is one IDLE cycle.
- Simultaneous IF and MEM requests in IDLE: MEM is granted. IF waits, with `if_stall_req_o` held high.
- `rdy` low:
  - State, k, latched request and outputs are frozen.
  - `ram_wr_o` is forced to 0.
  - Done pulses are extended; no handshake advances.
- `rst` mid-transaction: immediate return to IDLE on the next edge. Partial bytes are discarded and no done pulse is issued. A partial store may already have written its leading bytes.

## Configuration
- `MEM_CTRL_IF_FLUSH_EN` defined:
  - `flush_i` exists.
  - `flush_i` high in any active cycle of an IF-owned RD goes to IDLE at that edge, with no `if_done_o`, and `if_inst_o` unchanged.
  - `flush_i` is ignored for MEM transactions and in IDLE/DONE.
- Undefined: the port is absent and every fetch runs to completion.

## Test plan
- Fetch: RAM[0x100..0x103] = 13 05 A0 00, `if_req_i`, addr 0x100 → `ram_addr_o` 0x100..0x103 in cycles 1–4, `if_done_o` in cycle 6, `if_inst_o` = 0x00A00513.
- Signed byte load at 0x200 holding 0x85 → `mem_rdata_o` = 0xFFFFFF85. Unsigned → 0x00000085. Done in cycle 3.
- Half store 0xBEEF to 0x300 → `ram_wr_o` high in cycles 1–2 with (0x300, 0xEF) then (0x301, 0xBE). Done in cycle 3. No write in any other cycle.
- IF and MEM request together → MEM word load completes in cycle 6, IDLE in cycle 7, IF granted at the cycle-7 edge, `if_done_o` in cycle 13.
- `rdy` low for 3 cycles mid word load → done is delayed by exactly 3 cycles, data is correct, and `ram_wr_o` stays 0.
- With `MEM_CTRL_IF_FLUSH_EN`: `flush_i` in cycle 3 of a fetch → IDLE in cycle 4, no `if_done_o`, `if_inst_o` keeps its old value. A pending MEM request is granted next.
